// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and counter widths for the VGA sync generator.
// The defaults describe 800x600 at 60 Hz on a 40 MHz pixel clock.
package vga_timing_pkg;

    localparam int DEF_H_VIS  = 800;
    localparam int DEF_H_FP   = 40;
    localparam int DEF_H_SYNC = 128;
    localparam int DEF_H_BP   = 88;
    localparam int DEF_V_VIS  = 600;
    localparam int DEF_V_FP   = 1;
    localparam int DEF_V_SYNC = 4;
    localparam int DEF_V_BP   = 23;

    localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int H_W = 11;
    localparam int V_W = 10;
    localparam int F_W = 8;

    // True when val lies in the half-open window [lo, lo+len).
    function automatic logic in_span(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vga_wrap_cnt.sv
// Enabled modulo-TOTAL counter; wrap is high in the cycle whose edge returns
// the count to zero, so it can enable the next counter in a chain.
module vga_wrap_cnt #(
    parameter int W     = 11,
    parameter int TOTAL = 1056
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        wrap  = en && (cnt_q == LAST);
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: chained h/v wrap counters with a registered decode
// stage, so every output lags the counters by exactly one pixel clock.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic [H_W-1:0] pixel_x,
    output logic [V_W-1:0] pixel_y,
    output logic           line_start,
    output logic           frame_start,
    output logic [F_W-1:0] frame_cnt
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap;
    logic           v_wrap;

    vga_wrap_cnt #(.W(H_W), .TOTAL(H_TOT)) u_h_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (en),
        .cnt    (h_cnt),
        .wrap   (h_wrap)
    );

    // The vertical counter only moves on the last pixel of a line.
    vga_wrap_cnt #(.W(V_W), .TOTAL(V_TOT)) u_v_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap)
    );

    logic           hsync_d, hsync_q;
    logic           vsync_d, vsync_q;
    logic           video_on_d, video_on_q;
    logic [H_W-1:0] pixel_x_d, pixel_x_q;
    logic [V_W-1:0] pixel_y_d, pixel_y_q;
    logic           line_start_d, line_start_q;
    logic           frame_start_d, frame_start_q;
    logic [F_W-1:0] frame_cnt_d, frame_cnt_q;

    // Held outputs keep their level, but the start pulses drop so a stall
    // never stretches them into a repeated pulse.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = v_wrap ? frame_cnt_q + F_W'(1) : frame_cnt_q;
        if (en) begin
            hsync_d       = in_span(int'(h_cnt), H_VIS + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = in_span(int'(v_cnt), V_VIS + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on_d    = (int'(h_cnt) < H_VIS) && (int'(v_cnt) < V_VIS);
            pixel_x_d     = h_cnt;
            pixel_y_d     = v_cnt;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line-level behaviour and
// a shrunken, active-low instance for frame-level behaviour, both tracked by a model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vo;
        logic [10:0] x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } out_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit pol;
    } tim_t;

    typedef struct {
        int   pos;
        int   frames;
        out_t exp;
    } model_t;

    typedef struct {
        int   x;
        logic hs;
        logic vo;
        logic ls;
    } vec_a_t;

    typedef struct {
        int         k;
        int         y;
        logic       vs;
        logic [7:0] fc;
    } vec_b_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    logic        hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
    logic [10:0] pixel_x_a;
    logic [9:0]  pixel_y_a;
    logic [7:0]  frame_cnt_a;
    logic        hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
    logic [10:0] pixel_x_b;
    logic [9:0]  pixel_y_b;
    logic [7:0]  frame_cnt_b;

    out_t act_a, act_b;
    assign act_a = {hsync_a, vsync_a, video_on_a, pixel_x_a, pixel_y_a,
                    line_start_a, frame_start_a, frame_cnt_a};
    assign act_b = {hsync_b, vsync_b, video_on_b, pixel_x_b, pixel_y_b,
                    line_start_b, frame_start_b, frame_cnt_b};

    vga_sync_gen u_dut_a (
        .clk_in(clk), .rst_n(rst_n), .en(en_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_sync_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_dut_b (
        .clk_in(clk), .rst_n(rst_n), .en(en_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    tim_t tim_a = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1};
    tim_t tim_b = '{8, 2, 3, 3, 6, 1, 2, 1, 1'b0};
    model_t ma, mb;

    function automatic model_t model_reset(input tim_t t);
        model_t m;
        m.pos = 0;
        m.frames = 0;
        m.exp = '0;
        m.exp.hs = !t.pol;
        m.exp.vs = !t.pol;
        return m;
    endfunction

    // Position is a linear pixel index within the frame; x/y fall out of it.
    function automatic model_t step(input model_t m, input tim_t t, input logic e);
        model_t r;
        int ht, vt, x, y;
        r = m;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        if (!e) begin
            r.exp.ls = 1'b0;
            r.exp.fs = 1'b0;
            return r;
        end
        x = m.pos % ht;
        y = m.pos / ht;
        r.exp.hs = (x >= t.hv + t.hf && x < t.hv + t.hf + t.hs) ? t.pol : !t.pol;
        r.exp.vs = (y >= t.vv + t.vf && y < t.vv + t.vf + t.vs) ? t.pol : !t.pol;
        r.exp.vo = (x < t.hv) && (y < t.vv);
        r.exp.x  = 11'(x);
        r.exp.y  = 10'(y);
        r.exp.ls = (x == 0);
        r.exp.fs = (m.pos == 0);
        r.pos = (m.pos + 1) % (ht * vt);
        if (r.pos == 0) r.frames = m.frames + 1;
        r.exp.fc = 8'(r.frames % 256);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= model_reset(tim_a);
            mb <= model_reset(tim_b);
        end else begin
            ma <= step(ma, tim_a, en_a);
            mb <= step(mb, tim_b, en_b);
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic cmp_on = 1'b0;
    logic line_cnt_on = 1'b0;
    int hs_count = 0;
    int vo_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_a", 64'(act_a), 64'(ma.exp));
            chk("model_b", 64'(act_b), 64'(mb.exp));
        end
        if (line_cnt_on && pixel_y_a == 10'd0) begin
            if (hsync_a) hs_count <= hs_count + 1;
            if (video_on_a) vo_count <= vo_count + 1;
        end
    end

    task automatic wait_a_x(input int x);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(pixel_x_a) != x && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 3000) begin
            n_fail++;
            $display("FAIL wait_x_%0d: actual timeout required x=%0d", x, x);
        end
    endtask

    // ---------------- stimulus ----------------
    vec_a_t va[8];
    vec_b_t vb[9];
    int fs_b_count;
    int idx;

    initial begin
        va[0] = '{1,    1'b0, 1'b1, 1'b0};
        va[1] = '{799,  1'b0, 1'b1, 1'b0};
        va[2] = '{800,  1'b0, 1'b0, 1'b0};
        va[3] = '{839,  1'b0, 1'b0, 1'b0};
        va[4] = '{840,  1'b1, 1'b0, 1'b0};
        va[5] = '{967,  1'b1, 1'b0, 1'b0};
        va[6] = '{968,  1'b0, 1'b0, 1'b0};
        va[7] = '{1055, 1'b0, 1'b0, 1'b0};
        vb[0] = '{1,     0, 1'b1, 8'd0};
        vb[1] = '{97,    6, 1'b1, 8'd0};
        vb[2] = '{113,   7, 1'b0, 8'd0};
        vb[3] = '{129,   8, 1'b0, 8'd0};
        vb[4] = '{145,   9, 1'b1, 8'd0};
        vb[5] = '{160,   9, 1'b1, 8'd1};
        vb[6] = '{161,   0, 1'b1, 8'd1};
        vb[7] = '{40959, 9, 1'b1, 8'd255};
        vb[8] = '{40960, 9, 1'b1, 8'd0};

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_a", 64'(act_a), 64'(out_t'({1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 8'd0})));
        chk("reset_b", 64'(act_b), 64'(out_t'({1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 8'd0})));
        cmp_on = 1'b1;

        // Release with only the default instance running, and walk one line.
        line_cnt_on = 1'b1;
        rst_n = 1'b1;
        en_a = 1'b1;
        @(negedge clk);
        chk("first_edge_a", 64'(act_a), 64'(out_t'({1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1, 8'd0})));
        for (int i = 0; i < 8; i++) begin
            wait_a_x(va[i].x);
            chk($sformatf("line_x%0d", va[i].x), {61'd0, hsync_a, video_on_a, line_start_a},
                {61'd0, va[i].hs, va[i].vo, va[i].ls});
        end
        @(negedge clk);
        chk("line_wrap_xy", {pixel_x_a, pixel_y_a, line_start_a}, {11'd0, 10'd1, 1'b1});
        line_cnt_on = 1'b0;
        @(negedge clk);
        chk("hsync_width", 64'(hs_count), 64'd128);
        chk("video_width", 64'(vo_count), 64'd800);

        // Frame-level table on the small instance while the default one holds.
        en_a = 1'b0;
        en_b = 1'b1;
        fs_b_count = 0;
        idx = 0;
        for (int k = 1; k <= 40960; k++) begin
            @(negedge clk);
            if (frame_start_b) fs_b_count++;
            if (idx < 9 && vb[idx].k == k) begin
                chk($sformatf("frame_k%0d", k), {pixel_y_b, vsync_b, frame_cnt_b},
                    {10'(vb[idx].y), vb[idx].vs, vb[idx].fc});
                idx++;
            end
        end
        chk("frame_start_count", 64'(fs_b_count), 64'd256);

        // Random enable pattern, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en_a = ($urandom_range(0, 3) != 0);
            en_b = ($urandom_range(0, 3) != 0);
        end
        en_a = 1'b1;
        en_b = 1'b1;

        // Stall at x=500 for 10 cycles, then resume at 501.
        wait_a_x(500);
        en_a = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_x500", {pixel_x_a, hsync_a, line_start_a}, {11'd500, 1'b0, 1'b0});
        end
        en_a = 1'b1;
        @(negedge clk);
        chk("resume_x501", 64'(pixel_x_a), 64'd501);

        // Asynchronous reset mid-line, then restart from (0,0).
        wait_a_x(900);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clr_a", 64'(act_a), 64'(out_t'({1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 8'd0})));
        chk("async_clr_b", 64'(act_b), 64'(out_t'({1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 8'd0})));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_a", 64'(act_a), 64'(out_t'({1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1, 8'd0})));
        chk("restart_b", 64'(act_b), 64'(out_t'({1'b1, 1'b1, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1, 8'd0})));
        repeat (200) @(negedge clk);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VIS, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in pixel clocks.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in pixel clocks.
REQ-004 Parameter H_BP, default 88, horizontal back porch in pixel clocks.
REQ-005 Parameter V_VIS, default 600, visible lines per frame.
REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 4, vertical sync width in lines.
REQ-008 Parameter V_BP, default 23, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 1, active level of hsync and vsync (1 = active-high).
REQ-010 Port clk_in, input, 1, 40 MHz pixel clock taken from clk_40MHz clk_out; the only clock.
REQ-011 Port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-012 Port en, input, 1, timing advance enable.
REQ-013 Port hsync, output, 1, horizontal sync.
REQ-014 Port vsync, output, 1, vertical sync.
REQ-015 Port video_on, output, 1, high while the pixel is in the visible area.
REQ-016 Port pixel_x, output, 11, current horizontal count.
REQ-017 Port pixel_y, output, 10, current vertical count.
REQ-018 Port line_start, output, 1, one-cycle pulse at pixel_x == 0.
REQ-019 Port frame_start, output, 1, one-cycle pulse at pixel_x == 0 and pixel_y == 0.
REQ-020 Port frame_cnt, output, 8, count of completed frames.

Function
REQ-021 Horizontal counter h_cnt SHALL count 0..H_TOTAL-1, with H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (1056), and wrap to 0.
REQ-022 Vertical counter v_cnt SHALL increment only on an h_cnt wrap, counting 0..V_TOTAL-1 (V_TOTAL = 628), and wrap to 0.
REQ-023 When en=0, both counters and every registered output SHALL hold their values; pulses SHALL NOT repeat while held.
REQ-024 All outputs SHALL be registered: each output at edge n+1 decodes the counter values present at edge n, a fixed 1-cycle latency.
REQ-025 pixel_x and pixel_y SHALL equal the decoded h_cnt and v_cnt, zero-extended.
REQ-026 hsync SHALL be at SYNC_POL when h_cnt is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (840..967), and at ~SYNC_POL otherwise.
REQ-027 vsync SHALL be at SYNC_POL when v_cnt is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (601..604) for all h_cnt values, and at ~SYNC_POL otherwise.
REQ-028 video_on SHALL be 1 only when h_cnt < H_VIS and v_cnt < V_VIS.
REQ-029 Simultaneous h and v wrap (h_cnt=1055, v_cnt=627, en=1) SHALL:
- return both counters to 0;
- increment frame_cnt modulo 256, wrapping 255 to 0;
- produce frame_start and line_start together on the following edge.
REQ-030 Internal counter widths SHALL be the output widths; arithmetic SHALL NOT overflow for the default parameters.

Reset
REQ-031 rst_n=0 SHALL immediately clear h_cnt, v_cnt, frame_cnt, pixel_x, pixel_y, video_on, line_start and frame_start to 0, and drive hsync and vsync to ~SYNC_POL.
REQ-032 Assertion mid-frame SHALL abandon the frame; after release the first en=1 edge SHALL present pixel (0,0) with line_start=1 and frame_start=1.

Structure
REQ-033 Timing defaults, H_TOTAL, V_TOTAL and the counter widths SHALL live in a shared package vga_timing_pkg.
REQ-034 One sub-module, vga_wrap_cnt, SHALL implement a parameterised wrap counter (en, wrap-out), instantiated once for h and once for v.

Verification
REQ-035 Reset, then release with en=1: first edge gives x=0, y=0, video_on=1, line_start=1, frame_start=1, hsync=vsync=0.
REQ-036 Run one line: hsync=1 exactly for x=840..967 (128 cycles), video_on=0 from x=800, and x=1055 is followed by x=0 with y=1.
REQ-037 Run to y=601: vsync=1 for y=601..604 (4*1056 cycles), and vsync=0 at y=605.
REQ-038 Full frame (663168 cycles): frame_start pulses once per frame and frame_cnt increments 0->1; after 256 frames frame_cnt reads 0.
REQ-039 Drop en for 10 cycles at x=500: x stays 500, outputs are stable, and counting resumes at 501.
REQ-040 Assert rst_n=0 at x=900, y=300: outputs clear asynchronously within the same cycle, and after release the sequence restarts at (0,0) with frame_cnt=0.
